instr_loader: RTL

- Delivers 9-bit instruction words to the cpu core's INSTRUCTION/write_en input. It is the producer end of the interface the core consumes.
- Deserialises instructions arriving on a pin-limited serial link (SER_DIN/SER_VALID, framed by LOAD_EN) into a DEPTH-entry program buffer.
- On RUN, replays the buffer to the core one word per accepted cycle, under CPU_READY flow control.
- Sits between the chip IO pins and the cpu core.

---
 rtl/loader_pkg.sv | 23 ++
 rtl/instr_shift_in.sv | 73 +++++++
 rtl/instr_loader.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/loader_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Package     : loader_pkg                                             |
// | Description : Shared constants and state encodings for the serial    |
// |               instruction loader (instr_loader, instr_shift_in).     |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
package loader_pkg;

   // Default geometry: 9-bit core instructions, 8-entry program buffer.
   localparam int IW_DEF    = 9;
   localparam int DEPTH_DEF = 8;
   localparam int AW_DEF    = 3;

   typedef logic [1:0] state_t;

   localparam state_t C_ST_IDLE = 2'd0;
   localparam state_t C_ST_LOAD = 2'd1;
   localparam state_t C_ST_PLAY = 2'd2;
   localparam state_t C_ST_DONE = 2'd3;

endpackage : loader_pkg
`default_nettype wire

// File: rtl/instr_shift_in.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : instr_shift_in                                         |
// | Description : MSB-first serial-to-parallel deserialiser for one      |
// |               IW-bit instruction word, with bit counter.             |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
// | Ports                                                                |
// |   CLK, RESET      clock, async active-high reset                     |
// |   ser_din_i       serial data bit                                    |
// |   ser_valid_i     ser_din_i is sampled this cycle                    |
// |   enable_i        shifting allowed this cycle                        |
// |   clear_i         synchronous clear of shift register and counter    |
// |   word_valid_o    last bit of a word is being sampled this cycle     |
// |   word_o          completed word (valid with word_valid_o)           |
// |   partial_o       some bits of an incomplete word are held           |
// +----------------------------------------------------------------------+
module instr_shift_in
   import loader_pkg::*;
#(
   parameter int IW = IW_DEF
) (
   input  logic          CLK,
   input  logic          RESET,
   input  logic          ser_din_i,
   input  logic          ser_valid_i,
   input  logic          enable_i,
   input  logic          clear_i,
   output logic          word_valid_o,
   output logic [IW-1:0] word_o,
   output logic          partial_o
);

   localparam int BW = $clog2(IW);
   localparam logic [BW-1:0] C_LAST    = BW'(IW - 1);
   localparam logic [BW-1:0] C_BIT_ONE = BW'(1);

   logic [IW-1:0] shreg_q, shreg_d;
   logic [BW-1:0] bitcnt_q, bitcnt_d;
   logic          w_sample;

   assign w_sample = enable_i & ser_valid_i;

   always_comb begin
      shreg_d  = shreg_q;
      bitcnt_d = bitcnt_q;
      if (clear_i) begin
         shreg_d  = '0;
         bitcnt_d = '0;
      end else if (w_sample) begin
         shreg_d  = {shreg_q[IW-2:0], ser_din_i};
         bitcnt_d = (bitcnt_q == C_LAST) ? '0 : bitcnt_q + C_BIT_ONE;
      end
   end

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         shreg_q  <= '0;
         bitcnt_q <= '0;
      end else begin
         shreg_q  <= shreg_d;
         bitcnt_q <= bitcnt_d;
      end
   end

   // The completed word includes the bit being sampled right now, so the
   // consumer can store it on the same edge the last bit arrives.
   assign word_valid_o = w_sample & (bitcnt_q == C_LAST);
   assign word_o       = {shreg_q[IW-2:0], ser_din_i};
   assign partial_o    = (bitcnt_q != '0);

endmodule : instr_shift_in
`default_nettype wire

// File: rtl/instr_loader.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : instr_loader                                           |
// | Description : Loads a program over a serial link into a DEPTH-entry  |
// |               buffer and replays it to the cpu core under CPU_READY  |
// |               flow control.                                          |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
// | Ports                                                                |
// |   CLK, RESET      clock, async active-high reset                     |
// |   SER_DIN         serial instruction bit, MSB first                  |
// |   SER_VALID       SER_DIN sampled when high                          |
// |   LOAD_EN         load session frame                                 |
// |   RUN             level request to replay the buffer                 |
// |   CPU_READY       core accepts a word this cycle                     |
// |   INSTRUCTION     registered word to the core                        |
// |   write_en        registered one-cycle strobe for INSTRUCTION        |
// |   COUNT           complete words in the buffer (0..DEPTH)            |
// |   BUSY            state is not IDLE                                  |
// |   ERR             sticky overflow / truncated-word flag              |
// +----------------------------------------------------------------------+
module instr_loader
   import loader_pkg::*;
#(
   parameter int IW    = IW_DEF,
   parameter int DEPTH = DEPTH_DEF,
   parameter int AW    = AW_DEF
) (
   input  logic          CLK,
   input  logic          RESET,
   input  logic          SER_DIN,
   input  logic          SER_VALID,
   input  logic          LOAD_EN,
   input  logic          RUN,
   input  logic          CPU_READY,
   output logic [IW-1:0] INSTRUCTION,
   output logic          write_en,
   output logic [AW:0]   COUNT,
   output logic          BUSY,
   output logic          ERR
);

   localparam logic [AW:0]   C_FULL    = (AW + 1)'(DEPTH);
   localparam logic [AW:0]   C_CNT_ONE = (AW + 1)'(1);
   localparam logic [AW-1:0] C_PTR_ONE = AW'(1);

   state_t        state_q, state_d;

   logic [IW-1:0] mem_q [DEPTH];

   logic [AW:0]   count_q,  count_d;
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   // One bit wider than an address so "all COUNT words issued" is
   // distinguishable from "none issued" when the buffer is full.
   logic [AW:0]   rd_ptr_q, rd_ptr_d;
   logic          err_q,    err_d;
   logic [IW-1:0] instr_q,  instr_d;
   logic          wen_q,    wen_d;

   logic          w_shift_en;
   logic          w_shift_clr;
   logic          w_word_valid;
   logic [IW-1:0] w_word;
   logic          w_partial;
   logic          w_store;
   logic          w_issue;

   instr_shift_in #(
      .IW (IW)
   ) u_shift_in (
      .CLK          (CLK),
      .RESET        (RESET),
      .ser_din_i    (SER_DIN),
      .ser_valid_i  (SER_VALID),
      .enable_i     (w_shift_en),
      .clear_i      (w_shift_clr),
      .word_valid_o (w_word_valid),
      .word_o       (w_word),
      .partial_o    (w_partial)
   );

   // ---------------- FSM: state register ----------------
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         state_q <= C_ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // ---------------- FSM: next state ----------------
   always_comb begin
      state_d = state_q;
      case (state_q)
         C_ST_IDLE: begin
            if (LOAD_EN) begin
               state_d = C_ST_LOAD;
            end else if (RUN && (count_q != '0)) begin
               state_d = C_ST_PLAY;
            end
         end
         C_ST_LOAD: begin
            if (!LOAD_EN) begin
               state_d = C_ST_IDLE;
            end
         end
         C_ST_PLAY: begin
            // Move on the edge that issues the last word, so the first
            // DONE cycle carries that word's strobe.
            if (w_issue && ((rd_ptr_q + C_CNT_ONE) == count_q)) begin
               state_d = C_ST_DONE;
            end else if (rd_ptr_q >= count_q) begin
               state_d = C_ST_DONE;
            end
         end
         C_ST_DONE: begin
            if (!RUN) begin
               state_d = C_ST_IDLE;
            end
         end
         default: state_d = C_ST_IDLE;
      endcase
   end

   // ---------------- FSM: outputs / control ----------------
   always_comb begin
      BUSY        = (state_q != C_ST_IDLE);
      // Shifter is held clear while idle, so every load starts word-aligned
      // and any partial word from the previous session is discarded.
      w_shift_clr = (state_q == C_ST_IDLE);
      w_shift_en  = (state_q == C_ST_LOAD) && LOAD_EN;
      w_store     = w_word_valid && (count_q < C_FULL);
      w_issue     = (state_q == C_ST_PLAY) && CPU_READY && (rd_ptr_q < count_q);
   end

   // ---------------- Buffer and playback datapath ----------------
   always_comb begin
      count_d  = count_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      err_d    = err_q;
      instr_d  = instr_q;
      wen_d    = 1'b0;
      case (state_q)
         C_ST_IDLE: begin
            if (LOAD_EN) begin
               count_d  = '0;
               wr_ptr_d = '0;
               err_d    = 1'b0;
            end else if (RUN && (count_q != '0)) begin
               rd_ptr_d = '0;
            end
         end
         C_ST_LOAD: begin
            if (!LOAD_EN) begin
               if (w_partial) begin
                  err_d = 1'b1;
               end
            end else if (w_word_valid) begin
               if (w_store) begin
                  wr_ptr_d = wr_ptr_q + C_PTR_ONE;
                  count_d  = count_q + C_CNT_ONE;
               end else begin
                  err_d = 1'b1;
               end
            end
         end
         C_ST_PLAY: begin
            if (w_issue) begin
               instr_d  = mem_q[rd_ptr_q[AW-1:0]];
               wen_d    = 1'b1;
               rd_ptr_d = rd_ptr_q + C_CNT_ONE;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         count_q  <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         err_q    <= 1'b0;
         instr_q  <= '0;
         wen_q    <= 1'b0;
      end else begin
         count_q  <= count_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         err_q    <= err_d;
         instr_q  <= instr_d;
         wen_q    <= wen_d;
      end
   end

   // Buffer storage carries no reset; contents are only read below COUNT.
   always_ff @(posedge CLK) begin
      if (w_shift_en && w_store) begin
         mem_q[wr_ptr_q] <= w_word;
      end
   end

   assign INSTRUCTION = instr_q;
   assign write_en    = wen_q;
   assign COUNT       = count_q;
   assign ERR         = err_q;

endmodule : instr_loader
`default_nettype wire
